// File: rtl/btb_pkg.sv
// Shared definitions for the BTB update sequencer.
//
// Purpose:
//   Holds the BTB geometry constants, the layout of one queued branch
//   update, and the encoding of the update sequencer's state machine.
//   The sequencer and its queue import this package.
//
// Contents:
//   TAGW, SET_W, PC_W, TARGET_W  - BTB geometry and address widths
//   ENTRY_W                      - bits in one queued update (30+1+32)
//   btb_entry_t                  - packed queue entry {pc, taken, target}
//   ST_IDLE / ST_READ / ST_WRITE - sequencer state encoding
package btb_pkg;

    // BTB geometry: the word-aligned PC splits into tag and set index.
    localparam int TAGW     = 27;
    localparam int SET_W    = 3;
    localparam int PC_W     = 30;
    localparam int TARGET_W = 32;

    // One queued update is the resolved branch PC, direction and target.
    localparam int ENTRY_W  = PC_W + 1 + TARGET_W;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic                taken;
        logic [TARGET_W-1:0] target;
    } btb_entry_t;

    // Sequencer states, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

endpackage : btb_pkg

// File: rtl/btb_upd_fifo.sv
// Update queue for the BTB update sequencer.
//
// Purpose:
//   Small FIFO holding resolved branches waiting to be written into the
//   BTB. Pointers wrap modulo DEPTH; the occupancy counter runs 0..DEPTH
//   so a full queue is distinguishable from an empty one. Storage is not
//   reset; only the pointers and the count are.
//
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   push, din - write din at the tail this cycle (ignored when full)
//   pop       - retire the head entry this cycle (ignored when empty)
//   head      - the oldest queued entry (undefined when empty)
//   count     - occupancy, 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
module btb_upd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  btb_pkg::btb_entry_t      din,
    input  logic                     pop,
    output btb_pkg::btb_entry_t      head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import btb_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    btb_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Entry storage: written at the tail, never cleared by reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; a
    // simultaneous push and pop moves both pointers and keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : btb_upd_fifo

// File: rtl/btb_update_seq.sv
// BTB update sequencer.
//
// Purpose:
//   Queues resolved branches from the execute stage and replays each one
//   into the BTB as a read-modify-write: a READ cycle borrows the shared
//   BTB read port to fetch the target set, and the following WRITE cycle
//   drives btb_write with the head entry while the read data is valid.
//   Fetch has priority on the read port, but only at the moment a READ
//   would start; a READ or WRITE already under way always completes.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   ex_valid        - execute stage offers a resolved branch
//   ex_pc           - word-aligned PC of the branch
//   ex_taken        - resolved direction
//   ex_target       - resolved target
//   ex_ready        - queue accepts an offer this cycle
//   fetch_rd_busy   - fetch owns the BTB read port this cycle
//   upd_rd_en       - BTB set read request (READ state)
//   upd_rd_set      - set index being read
//   update_en       - btb_write strobe (WRITE state)
//   update_pc       - PC of the entry being written
//   actual_taken    - direction of the entry being written
//   update_target   - target of the entry being written
//   q_count         - current queue occupancy
module btb_update_seq #(
    parameter int TAGW  = btb_pkg::TAGW,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic [29:0]            ex_pc,
    input  logic                   ex_taken,
    input  logic [31:0]            ex_target,
    output logic                   ex_ready,
    input  logic                   fetch_rd_busy,
    output logic                   upd_rd_en,
    output logic [2:0]             upd_rd_set,
    output logic                   update_en,
    output logic [29:0]            update_pc,
    output logic                   actual_taken,
    output logic [31:0]            update_target,
    output logic [$clog2(DEPTH):0] q_count
);
    import btb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    btb_entry_t      din;
    btb_entry_t      head;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            in_read;
    logic            in_write;
    logic [TAGW-1:0] head_tag;

    // Offers are refused while reset is held so nothing slips into a
    // queue that is being cleared.
    assign ex_ready = !full && !rst;
    assign push     = ex_valid && ex_ready;
    assign din      = '{pc: ex_pc, taken: ex_taken, target: ex_target};

    // The head leaves at the end of its WRITE cycle, after btb_write has
    // seen the read data fetched in the preceding READ.
    assign pop = (state == ST_WRITE) && !rst;

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

    // Next-state logic. Fetch contention only defers the start of a READ;
    // READ always advances to WRITE. From WRITE another READ may follow
    // directly when entries remain behind the one being popped.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (!empty && !fetch_rd_busy) begin
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if ((q_count > CW'(1)) && !fetch_rd_busy) begin
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Moore outputs, forced quiet while reset is held so an interrupted
    // READ or WRITE never reaches the BTB.
    assign in_read  = (state == ST_READ) && !rst;
    assign in_write = (state == ST_WRITE) && !rst;

    // The PC is rebuilt from its tag and set fields so the BTB tag width
    // is tied to the PC layout at elaboration.
    assign head_tag = head.pc[SET_W +: TAGW];

    assign upd_rd_en     = in_read;
    assign upd_rd_set    = in_read  ? head.pc[SET_W-1:0]                  : '0;
    assign update_en     = in_write;
    assign update_pc     = in_write ? {head_tag, head.pc[SET_W-1:0]}     : '0;
    assign actual_taken  = in_write ? head.taken                          : 1'b0;
    assign update_target = in_write ? head.target                         : '0;

endmodule : btb_update_seq

// File: tb/tb_btb_update_seq.sv
// Directed testbench for btb_update_seq.
//
// Inputs change 1 ns after each rising edge and outputs are sampled at
// the same point, away from the active edge.
module tb_btb_update_seq;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [29:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_ready;
    logic        fetch_rd_busy;
    logic        upd_rd_en;
    logic [2:0]  upd_rd_set;
    logic        update_en;
    logic [29:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;
    logic [2:0]  q_count;

    int total = 0;
    int bad   = 0;

    btb_update_seq #(
        .TAGW  (27),
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_ready      (ex_ready),
        .fetch_rd_busy (fetch_rd_busy),
        .upd_rd_en     (upd_rd_en),
        .upd_rd_set    (upd_rd_set),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .actual_taken  (actual_taken),
        .update_target (update_target),
        .q_count       (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [29:0] pc, input logic tk, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_taken  = tk;
        ex_target = tgt;
    endtask

    task automatic checkRead(input string tag, input logic [2:0] set);
        checkOutput({tag, "_rd_en"}, 64'(upd_rd_en), 64'd1);
        checkOutput({tag, "_rd_set"}, 64'(upd_rd_set), 64'(set));
        checkOutput({tag, "_up_en_in_read"}, 64'(update_en), 64'd0);
    endtask

    task automatic checkWrite(input string tag, input logic [29:0] pc, input logic tk, input logic [31:0] tgt);
        checkOutput({tag, "_up_en"}, 64'(update_en), 64'd1);
        checkOutput({tag, "_up_pc"}, 64'(update_pc), 64'(pc));
        checkOutput({tag, "_up_taken"}, 64'(actual_taken), 64'(tk));
        checkOutput({tag, "_up_target"}, 64'(update_target), 64'(tgt));
        checkOutput({tag, "_rd_en_in_write"}, 64'(upd_rd_en), 64'd0);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_rd_en"}, 64'(upd_rd_en), 64'd0);
        checkOutput({tag, "_rd_set"}, 64'(upd_rd_set), 64'd0);
        checkOutput({tag, "_up_en"}, 64'(update_en), 64'd0);
        checkOutput({tag, "_up_pc"}, 64'(update_pc), 64'd0);
        checkOutput({tag, "_up_taken"}, 64'(actual_taken), 64'd0);
        checkOutput({tag, "_up_target"}, 64'(update_target), 64'd0);
    endtask

    task automatic applyStimulus();
        // ---- reset behaviour ----
        rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        fetch_rd_busy = 1'b0;
        step(); step();
        checkOutput("rst_ex_ready", 64'(ex_ready), 64'd0);
        checkOutput("rst_q_count", 64'(q_count), 64'd0);
        checkQuiet("rst_quiet");
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ex_ready", 64'(ex_ready), 64'd1);

        // ---- single push: READ at N+1, WRITE at N+2 ----
        offer(30'h15, 1'b1, 32'h400);
        step();
        ex_valid = 1'b0;
        checkOutput("single_count", 64'(q_count), 64'd1);
        checkQuiet("single_idle");
        step();
        checkRead("single_read", 3'd5);
        step();
        checkWrite("single_write", 30'h15, 1'b1, 32'h400);
        step();
        checkOutput("single_count_end", 64'(q_count), 64'd0);
        checkQuiet("single_done");

        // ---- fill to DEPTH under fetch contention, then drain ----
        fetch_rd_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(30'h101 + 30'(i), 1'(i % 2), 32'h1000 + 32'(i));
            step();
        end
        checkOutput("fill_count", 64'(q_count), 64'd4);
        checkOutput("fill_ready", 64'(ex_ready), 64'd0);
        checkQuiet("fill_blocked");
        offer(30'h1FF, 1'b1, 32'hDEAD);
        step();
        ex_valid = 1'b0;
        checkOutput("fill_5th_rejected", 64'(q_count), 64'd4);
        fetch_rd_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkRead("drain_read", 3'(1 + i));
            if (i == 0) begin
                checkOutput("drain_ready_before_pop", 64'(ex_ready), 64'd0);
            end
            if (i == 1) begin
                checkOutput("drain_ready_after_pop", 64'(ex_ready), 64'd1);
                checkOutput("drain_count_after_pop", 64'(q_count), 64'd3);
            end
            step();
            checkWrite("drain_write", 30'h101 + 30'(i), 1'(i % 2), 32'h1000 + 32'(i));
        end
        step();
        checkOutput("drain_count_end", 64'(q_count), 64'd0);
        checkQuiet("drain_done");

        // ---- two updates to the same set ----
        offer(30'h08, 1'b0, 32'h2000);
        step();
        offer(30'h48, 1'b1, 32'h3000);
        step();
        ex_valid = 1'b0;
        checkRead("same_read0", 3'd0);
        step();
        checkWrite("same_write0", 30'h08, 1'b0, 32'h2000);
        step();
        checkRead("same_read1", 3'd0);
        step();
        checkWrite("same_write1", 30'h48, 1'b1, 32'h3000);
        step();
        checkQuiet("same_done");

        // ---- fetch busy during WRITE with another entry queued ----
        offer(30'h20, 1'b1, 32'h5000);
        step();
        offer(30'h31, 1'b0, 32'h6000);
        step();
        ex_valid = 1'b0;
        checkRead("busy_read0", 3'd0);
        step();
        checkWrite("busy_write0", 30'h20, 1'b1, 32'h5000);
        fetch_rd_busy = 1'b1;
        step();
        checkQuiet("busy_idle0");
        checkOutput("busy_count", 64'(q_count), 64'd1);
        step();
        checkQuiet("busy_idle1");
        fetch_rd_busy = 1'b0;
        step();
        checkRead("busy_read1", 3'd1);
        step();
        checkWrite("busy_write1", 30'h31, 1'b0, 32'h6000);
        step();
        checkOutput("busy_count_end", 64'(q_count), 64'd0);

        // ---- reset in the middle of a WRITE with 3 queued ----
        fetch_rd_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(30'h70 + 30'(i), 1'b1, 32'h7000 + 32'(i));
            step();
        end
        ex_valid = 1'b0;
        fetch_rd_busy = 1'b0;
        step();
        checkRead("mid_read", 3'd0);
        step();
        checkWrite("mid_write", 30'h70, 1'b1, 32'h7000);
        checkOutput("mid_count", 64'(q_count), 64'd3);
        rst = 1'b1;
        #1;
        checkQuiet("mid_rst_held");
        step();
        checkOutput("mid_rst_count", 64'(q_count), 64'd0);
        checkOutput("mid_rst_ready", 64'(ex_ready), 64'd0);
        checkQuiet("mid_rst_quiet");
        rst = 1'b0;
        #1;
        checkOutput("mid_post_ready", 64'(ex_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("mid_no_update", 64'(update_en), 64'd0);
            checkOutput("mid_no_read", 64'(upd_rd_en), 64'd0);
        end
        checkOutput("mid_count_end", 64'(q_count), 64'd0);

        // ---- simultaneous push and pop at q_count=2 ----
        fetch_rd_busy = 1'b1;
        offer(30'h61, 1'b0, 32'h8001);
        step();
        offer(30'h62, 1'b1, 32'h8002);
        step();
        ex_valid = 1'b0;
        fetch_rd_busy = 1'b0;
        step();
        checkRead("pp_read0", 3'd1);
        step();
        checkWrite("pp_write0", 30'h61, 1'b0, 32'h8001);
        checkOutput("pp_count_before", 64'(q_count), 64'd2);
        offer(30'h63, 1'b1, 32'h8003);
        step();
        ex_valid = 1'b0;
        checkOutput("pp_count_after", 64'(q_count), 64'd2);
        checkRead("pp_read1", 3'd2);
        step();
        checkWrite("pp_write1", 30'h62, 1'b1, 32'h8002);
        step();
        checkRead("pp_read2", 3'd3);
        step();
        checkWrite("pp_write2", 30'h63, 1'b1, 32'h8003);
        step();
        checkOutput("pp_count_end", 64'(q_count), 64'd0);
        checkQuiet("pp_done");
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_btb_update_seq
